// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding and flag bit positions for the ALU result path
package alu_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI, DONE} alu_col_state_t;
  localparam int FLAG_C  = 0;
  localparam int FLAG_N  = 1;
  localparam int FLAG_PV = 2;
  localparam int FLAG_X  = 3;
  localparam int FLAG_H  = 4;
  localparam int FLAG_Y  = 5;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_S  = 7;
endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational Z80 flag byte from an assembled result
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int EVEN_PARITY = 1
) (
  input  logic [7:0] result,
  input  logic       h,
  input  logic       n,
  input  logic       c,
  input  logic       v,
  input  logic       parity_mode,
  output logic [7:0] flags
);
  logic par;
  always_comb begin
    par = (EVEN_PARITY != 0) ? ~^result : ^result;
    flags = '0;
    flags[FLAG_S]  = result[7];
    flags[FLAG_Z]  = result == 8'h00;
    flags[FLAG_Y]  = result[5];
    flags[FLAG_H]  = h;
    flags[FLAG_X]  = result[3];
    flags[FLAG_PV] = parity_mode ? par : v;
    flags[FLAG_N]  = n;
    flags[FLAG_C]  = c;
  end
endmodule

// File: rtl/alu_result_collector.sv
// alu_result_collector: reassembles two nibble passes into a byte plus flags behind valid/ready
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int EVEN_PARITY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       parity_mode,
  input  logic       n_in,
  input  logic       nib_valid,
  input  logic       nib_high,
  input  logic [3:0] nib_res,
  input  logic       nib_cy,
  input  logic       nib_vf,
  input  logic       res_ready,
  output logic       busy,
  output logic       res_valid,
  output logic [7:0] result,
  output logic [7:0] flags,
  output logic       proto_err
);
  alu_col_state_t state_q, state_d;
  logic [3:0] lo_q;
  logic       h_q, pm_q, n_q, perr_q, perr_d, lo_take, hi_take;
  logic [7:0] result_q, flags_q, flags_d;
  alu_flag_gen #(.EVEN_PARITY(EVEN_PARITY)) u_flag_gen (
    .result     ({nib_res, lo_q}),
    .h          (h_q),
    .n          (n_q),
    .c          (nib_cy),
    .v          (nib_vf),
    .parity_mode(pm_q),
    .flags      (flags_d)
  );
  // start overrides any nibble or handshake activity in the same cycle
  always_comb begin
    lo_take = !start && nib_valid && !nib_high && state_q == WAIT_LO;
    hi_take = !start && nib_valid && nib_high && state_q == WAIT_HI;
    perr_d  = !start && nib_valid && ((state_q == WAIT_LO && nib_high) || (state_q == WAIT_HI && !nib_high));
    state_d = start ? WAIT_LO :
              lo_take ? WAIT_HI :
              hi_take ? DONE :
              (state_q == DONE && res_ready) ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      h_q      <= 1'b0;
      pm_q     <= 1'b0;
      n_q      <= 1'b0;
      perr_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      perr_q  <= perr_d;
      if (start) begin
        lo_q <= '0;
        h_q  <= 1'b0;
        pm_q <= parity_mode;
        n_q  <= n_in;
      end else if (lo_take) begin
        lo_q <= nib_res;
        h_q  <= nib_cy;
      end
      if (hi_take) begin
        result_q <= {nib_res, lo_q};
        flags_q  <= flags_d;
      end
    end
  end
  assign busy      = state_q != IDLE;
  assign res_valid = state_q == DONE;
  assign result    = result_q;
  assign flags     = flags_q;
  assign proto_err = perr_q;
endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector: directed vectors with a queued scoreboard checked by a monitor
module tb_alu_result_collector;
  logic       clk = 1'b0;
  logic       reset, start, parity_mode, n_in, nib_valid, nib_high, nib_cy, nib_vf, res_ready;
  logic [3:0] nib_res;
  logic       busy, res_valid, proto_err;
  logic [7:0] result, flags;
  typedef struct packed {logic [7:0] r; logic [7:0] f;} exp_t;
  exp_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  alu_result_collector #(.EVEN_PARITY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .parity_mode(parity_mode), .n_in(n_in),
    .nib_valid(nib_valid), .nib_high(nib_high), .nib_res(nib_res), .nib_cy(nib_cy),
    .nib_vf(nib_vf), .res_ready(res_ready), .busy(busy), .res_valid(res_valid),
    .result(result), .flags(flags), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  // monitor: stability while held, scoreboard pop on each transfer
  logic       held = 1'b0;
  logic [7:0] prev_r, prev_f;
  always @(negedge clk) begin
    if (reset) held = 1'b0;
    else if (res_valid) begin
      if (held) begin
        check("hold_result", result, prev_r);
        check("hold_flags", flags, prev_f);
      end
      held = 1'b1;
      prev_r = result;
      prev_f = flags;
      if (res_ready) begin
        held = 1'b0;
        if (sb_q.size() == 0) check("unexpected_result", 8'h01, 8'h00);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          check("result", result, e.r);
          check("flags", flags, e.f);
        end
      end
    end else held = 1'b0;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic pm, input logic n);
    start = 1'b1;
    parity_mode = pm;
    n_in = n;
    cyc();
    start = 1'b0;
  endtask
  task automatic nib(input logic hi, input logic [3:0] r, input logic cy, input logic vf);
    nib_valid = 1'b1;
    nib_high = hi;
    nib_res = r;
    nib_cy = cy;
    nib_vf = vf;
    cyc();
    nib_valid = 1'b0;
  endtask
  task automatic push(input logic [7:0] r, input logic [7:0] f);
    sb_q.push_back({r, f});
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; parity_mode = 1'b0; n_in = 1'b0; nib_valid = 1'b0;
    nib_high = 1'b0; nib_res = '0; nib_cy = 1'b0; nib_vf = 1'b0; res_ready = 1'b1;
    cyc(); cyc();
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_valid", {7'd0, res_valid}, 8'h00);
    check("rst_perr", {7'd0, proto_err}, 8'h00);
    check("rst_result", result, 8'h00);
    check("rst_flags", flags, 8'h00);
    reset = 1'b0;
    cyc();
    // parity mode, back-to-back nibbles
    do_start(1'b1, 1'b0);
    check("t1_busy", {7'd0, busy}, 8'h01);
    nib(1'b0, 4'hA, 1'b1, 1'b0);
    check("t1_not_valid_yet", {7'd0, res_valid}, 8'h00);
    push(8'h5A, 8'h1C);
    nib(1'b1, 4'h5, 1'b0, 1'b0);
    check("t1_latency", {7'd0, res_valid}, 8'h01);
    cyc();
    check("t1_valid_drop", {7'd0, res_valid}, 8'h00);
    check("t1_busy_drop", {7'd0, busy}, 8'h00);
    // zero result
    do_start(1'b1, 1'b0);
    nib(1'b0, 4'h0, 1'b0, 1'b0);
    push(8'h00, 8'h45);
    nib(1'b1, 4'h0, 1'b1, 1'b0);
    cyc();
    // overflow mode
    do_start(1'b0, 1'b0);
    nib(1'b0, 4'h0, 1'b0, 1'b0);
    push(8'h80, 8'h84);
    nib(1'b1, 4'h8, 1'b0, 1'b1);
    cyc();
    // backpressure with an out-of-order low nibble in WAIT_HI
    res_ready = 1'b0;
    do_start(1'b1, 1'b1);
    nib(1'b0, 4'h9, 1'b0, 1'b0);
    nib(1'b0, 4'hF, 1'b1, 1'b0);
    check("t4_perr_hi", {7'd0, proto_err}, 8'h01);
    push(8'h69, 8'h2F);
    nib(1'b1, 4'h6, 1'b1, 1'b0);
    check("t4_valid", {7'd0, res_valid}, 8'h01);
    check("t4_perr_clear", {7'd0, proto_err}, 8'h00);
    cyc(); cyc(); cyc();
    check("t4_still_valid", {7'd0, res_valid}, 8'h01);
    check("t4_still_busy", {7'd0, busy}, 8'h01);
    res_ready = 1'b1;
    cyc();
    check("t4_valid_drop", {7'd0, res_valid}, 8'h00);
    check("t4_busy_drop", {7'd0, busy}, 8'h00);
    // protocol error in WAIT_LO
    do_start(1'b1, 1'b0);
    nib(1'b1, 4'h3, 1'b0, 1'b0);
    check("t5_perr", {7'd0, proto_err}, 8'h01);
    check("t5_busy", {7'd0, busy}, 8'h01);
    cyc();
    check("t5_perr_once", {7'd0, proto_err}, 8'h00);
    check("t5_no_valid", {7'd0, res_valid}, 8'h00);
    nib(1'b0, 4'h1, 1'b0, 1'b0);
    push(8'h21, 8'h24);
    nib(1'b1, 4'h2, 1'b0, 1'b0);
    cyc();
    // abort from WAIT_HI
    do_start(1'b1, 1'b1);
    nib(1'b0, 4'h7, 1'b1, 1'b0);
    do_start(1'b1, 1'b1);
    check("t6_no_valid", {7'd0, res_valid}, 8'h00);
    nib(1'b0, 4'h3, 1'b0, 1'b0);
    push(8'h43, 8'h02);
    nib(1'b1, 4'h4, 1'b0, 1'b0);
    cyc();
    // reset from WAIT_HI
    do_start(1'b1, 1'b0);
    nib(1'b0, 4'h5, 1'b0, 1'b0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t7_busy", {7'd0, busy}, 8'h00);
    check("t7_valid", {7'd0, res_valid}, 8'h00);
    check("t7_perr", {7'd0, proto_err}, 8'h00);
    check("t7_result", result, 8'h00);
    check("t7_flags", flags, 8'h00);
    nib(1'b1, 4'h2, 1'b0, 1'b0);
    check("t7_idle_perr", {7'd0, proto_err}, 8'h00);
    check("t7_idle_valid", {7'd0, res_valid}, 8'h00);
    check("t7_idle_busy", {7'd0, busy}, 8'h00);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) cyc();
    check("sb_drained", 8'(sb_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_result_collector.md
# alu_result_collector

Output-side counterpart of the ALU input shifter. The ALU core splits each 8-bit operation into two 4-bit passes, low nibble first. This block accepts the two nibble results in sequence and reassembles the 8-bit result. It generates the Z80 flag byte and holds both for the register/bus writer behind a valid/ready handshake.

## Interface
Parameters:
- EVEN_PARITY, default 1: P/V in parity mode is 1 when the result has an even number of ones; 0 inverts the sense.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a new operation; samples mode inputs
- parity_mode  in  1  1: P/V = parity; 0: P/V = nib_vf; sampled on accepted start
- n_in  in  1  N flag value for this operation; sampled on accepted start
- nib_valid  in  1  a nibble result is presented this cycle
- nib_high  in  1  0 = low nibble, 1 = high nibble
- nib_res  in  4  nibble result
- nib_cy  in  1  carry out of this nibble pass
- nib_vf  in  1  signed overflow; meaningful only with nib_high=1
- res_ready  in  1  consumer accepts result
- busy  out  1  state is not IDLE
- res_valid  out  1  result and flags are valid
- result  out  8  assembled byte {high, low}
- flags  out  8  {S,Z,Y,H,X,PV,N,C}, bit 7 .. bit 0
- proto_err  out  1  one-cycle pulse on an out-of-order nibble

## Operation
- States: IDLE, WAIT_LO, WAIT_HI, DONE.
- IDLE: start=1 -> WAIT_LO. The low/high latches clear, parity_mode and n_in are captured, and nib_valid is ignored that cycle.
- WAIT_LO:
  - nib_valid & !nib_high: latch low = nib_res and H = nib_cy, then -> WAIT_HI.
  - nib_valid & nib_high: proto_err pulses for one cycle; state unchanged.
- WAIT_HI:
  - nib_valid & nib_high: latch high = nib_res, C = nib_cy, V = nib_vf, then -> DONE.
  - nib_valid & !nib_high: proto_err pulses for one cycle; state unchanged; low latch is not overwritten.
- DONE: res_valid=1. res_ready=1 -> IDLE.
- start while in WAIT_LO, WAIT_HI or DONE:
  - Aborts the operation and restarts in WAIT_LO with fresh captures; any pending result is dropped.
  - start takes priority over a simultaneous nib_valid or res_ready.
- Flags are computed from the assembled byte R on the edge that enters DONE:
  - S = R[7]; Z = (R == 0); Y = R[5]; X = R[3].
  - H = latched low-nibble carry; N = captured n_in; C = high-nibble carry.
  - PV = parity_mode ? (EVEN_PARITY ? ~^R : ^R) : V.
- result and flags stay stable for the whole DONE residency. After the handshake they hold their last value until the next DONE entry.

## Timing
- Reset values: state IDLE; busy, res_valid, proto_err, result and flags all 0. Reset takes effect on the next edge from any state, including mid-operation.
- Latency: the high-nibble accept edge is also the edge that asserts res_valid. Result is visible the cycle after the high nibble is presented.
- Minimum operation length: start, low, high, handshake = 4 cycles, with back-to-back nibbles and res_ready tied high.
- Handshake:
  - Transfer occurs on an edge where res_valid & res_ready.
  - res_valid deasserts the following cycle; busy drops the same cycle.
  - res_ready while res_valid=0 has no effect.
- proto_err is registered: high exactly one cycle, the cycle after the offending nib_valid.
- nib_valid in IDLE or DONE is ignored without error.

## Structure
- Shared package alu_pkg holds:
  - state enum alu_col_state_t {IDLE, WAIT_LO, WAIT_HI, DONE};
  - flag bit index constants FLAG_C=0, FLAG_N=1, FLAG_PV=2, FLAG_X=3, FLAG_H=4, FLAG_Y=5, FLAG_Z=6, FLAG_S=7.
- One sub-module, alu_flag_gen:
  - purely combinational;
  - inputs: 8-bit result, h, n, c, v, parity_mode;
  - parameter EVEN_PARITY;
  - output: flag byte.
- The collector keeps the FSM, latches and handshake registers.

## Test plan
- Parity mode, n_in=0, nibbles sent back-to-back:
  - Stimulus: start; low 0xA with cy=1; high 0x5 with cy=0.
  - Required: result=0x5A, flags=0x1C; res_valid the cycle after the high nibble.
- Zero result, parity mode:
  - Stimulus: start; low 0x0 with cy=0; high 0x0 with cy=1.
  - Required: result=0x00, flags=0x45.
- Overflow mode (parity_mode=0):
  - Stimulus: start; low 0x0; high 0x8 with vf=1, cy=0.
  - Required: result=0x80, flags=0x84.
- Backpressure:
  - Stimulus: hold res_ready=0 for 3 cycles in DONE, then 1.
  - Required: res_valid, result and flags stable throughout; res_valid and busy fall the cycle after the transfer.
- Protocol error:
  - Stimulus: high nibble 0x3 presented in WAIT_LO.
  - Required: proto_err pulses once; state stays WAIT_LO; a following low 0x1, high 0x2 gives 0x21.
- Abort and reset:
  - Stimulus: start in WAIT_HI.
  - Required: back to WAIT_LO and the next result uses only new nibbles.
  - Stimulus: reset in WAIT_HI.
  - Required: next cycle all outputs 0 and state IDLE.
